phased_clock_gen: RTL and testbench
===================================

Name: phased_clock_gen

Overview:
- Synthesizable, runtime-configurable successor to the fixed-period simulation clock generator.
- From one fast clock `eclk`, derives NUM_CH divided clock/strobe outputs. Each output has its own half-period and phase offset in eclk cycles.
- Also produces a sequenced active-high reset for downstream logic.
- Used in benches and on FPGA to generate phase-related sclk/eclk_90/eclk_270-style clocks without hard-coded delays.

Parameters:
- NUM_CH, 4, number of output channels
- DIV_W, 8, width of half-period and phase fields
- RST_CYCLES, 16, eclk cycles `rst_out` stays high after start (≥1)
- CH_W, $clog2(NUM_CH) (min 1), channel-index width

Ports:
- eclk  in  1  single clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when valid&ready
- cfg_ch  in  CH_W  channel index
- cfg_half  in  DIV_W  half-period in eclk cycles (0 treated as 1)
- cfg_phase  in  DIV_W  start delay in eclk cycles
- cfg_en  in  1  channel enable
- start  in  1  pulse: apply shadow config, restart all channels
- stop  in  1  pulse: halt all channels
- clk_out  out  NUM_CH  generated clocks
- rst_out  out  1  sequenced reset, active-high
- locked  out  1  all enabled channels running

Behaviour:
- Reset (`reset`=0, async):
  - clk_out=all 1s, rst_out=1, locked=0, cfg_ready=1.
  - Shadow and active regs cleared: half=0, phase=0, en=0.
  - Top FSM to IDLE.
- Config:
  - On valid&ready, shadow[cfg_ch] <= {cfg_half, cfg_phase, cfg_en}.
  - cfg_ch ≥ NUM_CH: write accepted and discarded.
  - Shadow changes never affect running outputs until the next start.
- Top FSM states: IDLE, APPLY, RUN.
  - IDLE: start → APPLY.
  - APPLY: one cycle. cfg_ready=0; active <= shadow for all channels; → RUN.
  - RUN: start → APPLY (restart); stop → IDLE.
  - start and stop in the same cycle: stop wins.
  - cfg_valid during APPLY is held off by cfg_ready=0, then accepted next cycle into shadow.
- Per-channel FSM: OFF, PHASE, ON.
  - On APPLY exit, each enabled channel enters PHASE. clk_out=1, cnt=phase+h, where h=max(half,1), computed at DIV_W+1 bits.
  - Each cycle: cnt decrements. When cnt==1, clk_out toggles, cnt reloads h, state=ON.
  - Result: with APPLY at edge T, the first toggle is at edge T+1+phase+h, then every h cycles. Period = 2h.
  - Disabled channels stay OFF with clk_out=1.
  - Entering IDLE (stop): all channels go OFF, clk_out=1 the next cycle.
- rst_out:
  - 1 in IDLE and APPLY.
  - In RUN, counts RST_CYCLES cycles, then drops to 0 and stays 0 until the next APPLY or IDLE.
  - A restart re-asserts it.
- locked:
  - 1 in RUN when every enabled channel is in ON.
  - 1 in RUN if no channel is enabled.
  - Otherwise 0, including in IDLE and APPLY.
- Reset mid-operation: immediate async return to reset values. Shadow config is lost.

Test Plan:
- Reset then idle → clk_out=4'b1111, rst_out=1, locked=0, cfg_ready=1 for 20 cycles.
- ch0 half=2 phase=0 en=1; start at edge T → clk_out[0] falls at T+3, rises T+5, period 4; locked=1 from T+3; rst_out falls at T+1+RST_CYCLES.
- Quadrature set, half=4 on ch0..3 with phase 0,2,4,6 → rising edges spaced 2 cycles apart, ch2 = inverted ch0; matches eclk/eclk_90/eclk_270 relationship.
- half=0 en=1 → behaves as half=1 (toggle every cycle); cfg_ch=5 write → no shadow change, all channels unaffected.
- Rewrite ch0 half while running → output unchanged until next start; start+stop in same cycle → IDLE, clk_out=1s, rst_out=1.
- Assert reset low mid-RUN between clock edges → outputs return to reset values immediately; post-reset start with no writes → locked=1, all clk_out=1.

Source files
------------

// File: rtl/phased_clock_gen.sv
// Divided/phase-shifted clock generator with sequenced reset; config writes go to a shadow bank,
// copied to the active bank in a single APPLY cycle (cfg_ready low only then); outputs are registered.
module phased_clock_gen #(
  parameter int NUM_CH     = 4,
  parameter int DIV_W      = 8,
  parameter int RST_CYCLES = 16,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              eclk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_half,
  input  logic [DIV_W-1:0]  cfg_phase,
  input  logic              cfg_en,
  input  logic              start,
  input  logic              stop,
  output logic [NUM_CH-1:0] clk_out,
  output logic              rst_out,
  output logic              locked
);
  localparam int CNT_W = DIV_W + 1;
  localparam int RC_W  = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {TOP_IDLE, TOP_APPLY, TOP_RUN} top_state_e;
  typedef enum logic [1:0] {CH_OFF, CH_PHASE, CH_ON} ch_state_e;

  typedef struct packed {
    logic [DIV_W-1:0] half;
    logic [DIV_W-1:0] phase;
    logic             en;
  } ch_cfg_t;

  top_state_e        top_q, top_d;
  ch_cfg_t           shadow_q [NUM_CH];
  ch_cfg_t           shadow_d [NUM_CH];
  ch_cfg_t           active_q [NUM_CH];
  ch_cfg_t           active_d [NUM_CH];
  ch_state_e         ch_q     [NUM_CH];
  ch_state_e         ch_d     [NUM_CH];
  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;

  logic apply_exit;
  logic go_idle;
  logic all_on;

  // A half-period of zero would stall the counter, so it runs as one.
  function automatic logic [CNT_W-1:0] eff_half(input logic [DIV_W-1:0] half);
    return (half == '0) ? CNT_W'(1) : {1'b0, half};
  endfunction

  always_comb begin
    top_d     = top_q;
    cfg_ready = (top_q != TOP_APPLY);
    case (top_q)
      TOP_IDLE:  if (start && !stop) top_d = TOP_APPLY;
      TOP_APPLY: top_d = TOP_RUN;
      TOP_RUN: begin
        if (stop)       top_d = TOP_IDLE;
        else if (start) top_d = TOP_APPLY;
      end
      default:   top_d = TOP_IDLE;
    endcase
  end

  assign apply_exit = (top_q == TOP_APPLY);
  assign go_idle    = (top_q == TOP_RUN) && stop;

  // Out-of-range channel indices match no entry, so the write is silently dropped.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      shadow_d[i] = shadow_q[i];
      if (cfg_valid && cfg_ready && (cfg_ch == CH_W'(i)))
        shadow_d[i] = {cfg_half, cfg_phase, cfg_en};
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      active_d[i] = active_q[i];
      ch_d[i]     = ch_q[i];
      cnt_d[i]    = cnt_q[i];
      clk_d[i]    = clk_q[i];
      if (apply_exit) begin
        active_d[i] = shadow_q[i];
        clk_d[i]    = 1'b1;
        if (shadow_q[i].en) begin
          ch_d[i]  = CH_PHASE;
          cnt_d[i] = {1'b0, shadow_q[i].phase} + eff_half(shadow_q[i].half);
        end else begin
          ch_d[i]  = CH_OFF;
          cnt_d[i] = '0;
        end
      end else if (go_idle) begin
        ch_d[i]  = CH_OFF;
        cnt_d[i] = '0;
        clk_d[i] = 1'b1;
      end else if (ch_q[i] != CH_OFF) begin
        if (cnt_q[i] == CNT_W'(1)) begin
          clk_d[i] = ~clk_q[i];
          cnt_d[i] = eff_half(active_q[i].half);
          ch_d[i]  = CH_ON;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rst_cnt_d = rst_cnt_q;
    if (apply_exit)
      rst_cnt_d = RC_W'(RST_CYCLES);
    else if ((top_q == TOP_RUN) && (rst_cnt_q != '0))
      rst_cnt_d = rst_cnt_q - RC_W'(1);
  end

  always_comb begin
    all_on = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (active_q[i].en && (ch_q[i] != CH_ON)) all_on = 1'b0;
    end
  end

  assign locked  = (top_q == TOP_RUN) && all_on;
  assign rst_out = (top_q != TOP_RUN) || (rst_cnt_q != '0);
  assign clk_out = clk_q;

  always_ff @(posedge eclk or negedge reset) begin
    if (!reset) begin
      top_q     <= TOP_IDLE;
      clk_q     <= '1;
      rst_cnt_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
        ch_q[i]     <= CH_OFF;
        cnt_q[i]    <= '0;
      end
    end else begin
      top_q     <= top_d;
      clk_q     <= clk_d;
      rst_cnt_q <= rst_cnt_d;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
        ch_q[i]     <= ch_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end
endmodule

// File: tb/tb_phased_clock_gen.sv
// Bench for phased_clock_gen: directed scenarios plus random traffic against an arithmetic model.
module tb_phased_clock_gen;
  localparam int NUM_CH     = 4;
  localparam int DIV_W      = 8;
  localparam int RST_CYCLES = 16;
  localparam int CH_W       = 3;

  logic              eclk = 1'b0;
  logic              reset = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_en = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [DIV_W-1:0]  cfg_half = '0;
  logic [DIV_W-1:0]  cfg_phase = '0;
  logic              cfg_ready;
  logic              rst_out;
  logic              locked;
  logic [NUM_CH-1:0] clk_out;

  int checks = 0;
  int errors = 0;

  phased_clock_gen #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .RST_CYCLES(RST_CYCLES), .CH_W(CH_W)
  ) dut (
    .eclk(eclk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_half(cfg_half), .cfg_phase(cfg_phase), .cfg_en(cfg_en),
    .start(start), .stop(stop),
    .clk_out(clk_out), .rst_out(rst_out), .locked(locked)
  );

  always #5 eclk = ~eclk;

  // Model: each running channel is described by its load edge, first-toggle delay and half-period.
  int cyc = 0;
  int m_state;  // 0 idle, 1 apply, 2 run
  int run_cyc;
  int sh_half [NUM_CH];
  int sh_phase[NUM_CH];
  bit sh_en   [NUM_CH];
  bit act_en  [NUM_CH];
  int act_h   [NUM_CH];
  int act_n   [NUM_CH];
  int load_cyc[NUM_CH];

  always @(posedge eclk or negedge reset) begin
    if (!reset) begin
      m_state = 0;
      run_cyc = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        sh_half[i] = 0; sh_phase[i] = 0; sh_en[i] = 0;
        act_en[i] = 0; act_h[i] = 1; act_n[i] = 1; load_cyc[i] = 0;
      end
    end else begin
      cyc++;
      if (cfg_valid && m_state != 1 && int'(cfg_ch) < NUM_CH) begin
        sh_half[cfg_ch]  = int'(cfg_half);
        sh_phase[cfg_ch] = int'(cfg_phase);
        sh_en[cfg_ch]    = cfg_en;
      end
      case (m_state)
        0: if (start && !stop) m_state = 1;
        1: begin
          for (int i = 0; i < NUM_CH; i++) begin
            act_en[i]   = sh_en[i];
            act_h[i]    = (sh_half[i] == 0) ? 1 : sh_half[i];
            act_n[i]    = sh_phase[i] + act_h[i];
            load_cyc[i] = cyc;
          end
          run_cyc = cyc;
          m_state = 2;
        end
        default: begin
          if (stop) begin
            m_state = 0;
            for (int i = 0; i < NUM_CH; i++) act_en[i] = 0;
          end else if (start) begin
            m_state = 1;
          end
        end
      endcase
    end
  end

  function automatic logic exp_clk(int i);
    int t, k;
    if (!act_en[i]) return 1'b1;
    t = cyc - load_cyc[i];
    if (t < act_n[i]) return 1'b1;
    k = (t - act_n[i]) / act_h[i] + 1;
    return ((k % 2) == 0);
  endfunction

  function automatic logic exp_locked();
    if (m_state != 2) return 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (act_en[i] && (cyc - load_cyc[i]) < act_n[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  always @(negedge eclk) begin
    logic [NUM_CH-1:0] e;
    for (int i = 0; i < NUM_CH; i++) e[i] = exp_clk(i);
    chk("model_clk_out", 32'(clk_out), 32'(e));
    chk("model_rst_out", 32'(rst_out), 32'(!(m_state == 2 && (cyc - run_cyc) >= RST_CYCLES)));
    chk("model_locked", 32'(locked), 32'(exp_locked()));
    chk("model_cfg_ready", 32'(cfg_ready), 32'(m_state != 1));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge eclk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [CH_W-1:0] ch, input logic [DIV_W-1:0] h,
                           input logic [DIV_W-1:0] p, input logic en);
    logic rdy;
    int   n;
    n = 0;
    cfg_valid = 1'b1; cfg_ch = ch; cfg_half = h; cfg_phase = p; cfg_en = en;
    do begin
      rdy = cfg_ready;
      tick(1);
      n++;
    end while (!rdy && n < 8);
    chk("cfg_write_accept", 32'(rdy), 32'd1);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic p);
    start = s; stop = p;
    tick(1);
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    // Reset, then idle.
    tick(3);
    chk("rst_clk_out", 32'(clk_out), 32'hf);
    chk("rst_rst_out", 32'(rst_out), 32'd1);
    chk("rst_locked", 32'(locked), 32'd0);
    #2 reset = 1'b1;
    tick(20);
    chk("idle_clk_out", 32'(clk_out), 32'hf);
    chk("idle_cfg_ready", 32'(cfg_ready), 32'd1);

    // ch0 half=2 phase=0; start sampled at edge T.
    cfg_write(0, 2, 0, 1'b1);
    pulse(1'b1, 1'b0);                        // now just after T
    chk("ch0_apply_ready", 32'(cfg_ready), 32'd0);
    tick(2);  chk("ch0_T2_high", 32'(clk_out[0]), 32'd1);
              chk("ch0_T2_unlocked", 32'(locked), 32'd0);
    tick(1);  chk("ch0_T3_fall", 32'(clk_out[0]), 32'd0);
              chk("ch0_T3_locked", 32'(locked), 32'd1);
    tick(2);  chk("ch0_T5_rise", 32'(clk_out[0]), 32'd1);
    tick(2);  chk("ch0_T7_fall", 32'(clk_out[0]), 32'd0);
    tick(9);  chk("ch0_T16_rst_hi", 32'(rst_out), 32'd1);
    tick(1);  chk("ch0_T17_rst_lo", 32'(rst_out), 32'd0);

    // Quadrature set written while running, then restart.
    for (int i = 0; i < NUM_CH; i++) cfg_write(CH_W'(i), 4, DIV_W'(2 * i), 1'b1);
    pulse(1'b1, 1'b0);
    chk("quad_restart_rst", 32'(rst_out), 32'd1);
    tick(5);  chk("quad_T5", 32'(clk_out), 32'b1110);
    tick(4);  chk("quad_T9", 32'(clk_out), 32'b1001);
    tick(2);  chk("quad_T11", 32'(clk_out), 32'b0011);
    tick(30);

    // half=0 behaves as half=1; out-of-range channel write is dropped.
    cfg_write(0, 4, 0, 1'b0);
    cfg_write(1, 0, 0, 1'b1);
    cfg_write(2, 4, 0, 1'b0);
    cfg_write(3, 4, 0, 1'b0);
    cfg_write(5, 3, 0, 1'b1);
    pulse(1'b1, 1'b0);
    tick(1);  chk("h0_T1", 32'(clk_out), 32'b1111);
    tick(1);  chk("h0_T2", 32'(clk_out), 32'b1101);
              chk("h0_T2_locked", 32'(locked), 32'd1);
    tick(1);  chk("h0_T3", 32'(clk_out), 32'b1111);
    tick(10);

    // Shadow rewrite while running must not disturb outputs; then start+stop together.
    cfg_write(1, 7, 3, 1'b1);
    tick(12);
    pulse(1'b1, 1'b1);
    chk("startstop_clk", 32'(clk_out), 32'hf);
    chk("startstop_rst", 32'(rst_out), 32'd1);
    chk("startstop_locked", 32'(locked), 32'd0);
    pulse(1'b1, 1'b0);
    tick(40);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 8)
        cfg_write(CH_W'($urandom_range(0, 7)), DIV_W'($urandom_range(0, 5)),
                  DIV_W'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
      else if (r < 10) pulse(1'b1, 1'b0);
      else if (r < 11) pulse(1'b0, 1'b1);
      else if (r < 12) pulse(1'b1, 1'b1);
      else tick(1);
    end

    // Asynchronous reset between edges while running.
    pulse(1'b1, 1'b0);
    tick(6);
    #2 reset = 1'b0;
    #1;
    chk("areset_clk_out", 32'(clk_out), 32'hf);
    chk("areset_rst_out", 32'(rst_out), 32'd1);
    chk("areset_locked", 32'(locked), 32'd0);
    chk("areset_cfg_ready", 32'(cfg_ready), 32'd1);
    tick(3);
    #3 reset = 1'b1;
    tick(1);
    pulse(1'b1, 1'b0);
    tick(1);  chk("post_rst_locked", 32'(locked), 32'd1);
              chk("post_rst_clk", 32'(clk_out), 32'hf);
    tick(20); chk("post_rst_rst_lo", 32'(rst_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
